// File: rtl/ddr3_bank_model.sv
// ddr3_bank_model: single-bank DDR3 device responder enforcing tRCD/tRAS/tRP, with CL read pipeline and violation flags.
// Optional statistics counters: define DDR3_BANK_MODEL_STATS_EN. Rev 1.0
`default_nettype none

package ddr3_pkg;
   typedef enum logic [2:0] {
      CMD_NOP = 3'd0,
      CMD_ACT = 3'd1,
      CMD_RD  = 3'd2,
      CMD_WR  = 3'd3,
      CMD_PRE = 3'd4
   } ddr3_cmd_t;
   localparam int DDR3_ROW_BITS   = 13;
   localparam int DDR3_COL_BITS   = 10;
   localparam int DDR3_ADDR_WIDTH = 13;
endpackage

module ddr3_bank_model #(
   parameter int BANK_ID  = 0,
   parameter int T_RCD    = 3,
   parameter int T_RAS    = 8,
   parameter int T_RP     = 3,
   parameter int CL       = 5,
   parameter int ROW_BITS = ddr3_pkg::DDR3_ROW_BITS,
   parameter int COL_BITS = ddr3_pkg::DDR3_COL_BITS
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   cmd_valid,
   input  ddr3_pkg::ddr3_cmd_t                    cmd_type,
   input  logic [2:0]                             cmd_bank,
   input  logic [ddr3_pkg::DDR3_ADDR_WIDTH-1:0]   cmd_addr,
   output logic                                   bank_open,
   output logic [ROW_BITS-1:0]                    open_row,
   output logic                                   rd_valid,
   output logic [COL_BITS-1:0]                    rd_col,
   output logic                                   wr_ack,
   output logic                                   err_pulse,
   output logic [2:0]                             err_code,
   output logic [7:0]                             err_count,
   output logic [15:0]                            act_count,
   output logic [15:0]                            rd_count,
   output logic [15:0]                            wr_count
);
   import ddr3_pkg::*;

   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_ACTIVATING  = 2'd1,
      ST_ACTIVE      = 2'd2,
      ST_PRECHARGING = 2'd3
   } state_t;

   // State registers advance one cycle early so the new state is visible exactly at t+T_RCD / p+T_RP.
   localparam logic [7:0] C_RCD_THR = (T_RCD > 1) ? 8'(T_RCD - 1) : 8'd0;
   localparam logic [7:0] C_RP_THR  = (T_RP > 1) ? 8'(T_RP - 1) : 8'd0;
   localparam logic [7:0] C_RAS     = 8'(T_RAS);
   localparam logic [7:0] C_RP      = 8'(T_RP);
   localparam state_t     C_ACT_DEST = (T_RCD <= 1) ? ST_ACTIVE : ST_ACTIVATING;
   localparam state_t     C_PRE_DEST = (T_RP <= 1) ? ST_IDLE : ST_PRECHARGING;

   state_t               r_state, w_next_state;
   logic [7:0]           r_since_act, r_since_pre;
   logic                 w_accept;
   logic                 w_act_ok, w_rd_ok, w_wr_ok, w_pre_ok, w_err;
   logic [2:0]           w_err_code;
   logic [CL-1:0]        r_pipe_v;
   logic [COL_BITS-1:0]  r_pipe_col [CL];

   assign w_accept = cmd_valid && (cmd_bank == 3'(BANK_ID));

   always_comb begin
      w_next_state = r_state;
      w_act_ok     = 1'b0;
      w_rd_ok      = 1'b0;
      w_wr_ok      = 1'b0;
      w_pre_ok     = 1'b0;
      w_err        = 1'b0;
      w_err_code   = 3'd0;
      case (r_state)
         ST_ACTIVATING:  if (r_since_act >= C_RCD_THR) w_next_state = ST_ACTIVE;
         ST_PRECHARGING: if (r_since_pre >= C_RP_THR) w_next_state = ST_IDLE;
         default: ;
      endcase
      if (w_accept) begin
         case (cmd_type)
            CMD_NOP: ;
            CMD_ACT: begin
               if (r_state == ST_IDLE || (r_state == ST_PRECHARGING && r_since_pre >= C_RP)) begin
                  w_act_ok = 1'b1;
               end else if (r_state == ST_PRECHARGING) begin
                  w_err = 1'b1; w_err_code = 3'd5;
               end else begin
                  w_err = 1'b1; w_err_code = 3'd4;
               end
            end
            CMD_RD, CMD_WR: begin
               if (r_state == ST_ACTIVE) begin
                  w_rd_ok = (cmd_type == CMD_RD);
                  w_wr_ok = (cmd_type == CMD_WR);
               end else if (r_state == ST_ACTIVATING) begin
                  w_err = 1'b1; w_err_code = 3'd2;
               end else begin
                  w_err = 1'b1; w_err_code = 3'd1;
               end
            end
            CMD_PRE: begin
               // PRE to an already closed bank is a harmless no-op.
               if (r_state == ST_ACTIVE && r_since_act >= C_RAS) begin
                  w_pre_ok = 1'b1;
               end else if (r_state == ST_ACTIVE || r_state == ST_ACTIVATING) begin
                  w_err = 1'b1; w_err_code = 3'd3;
               end
            end
            default: begin
               w_err = 1'b1; w_err_code = 3'd6;
            end
         endcase
         if (w_act_ok) w_next_state = C_ACT_DEST;
         if (w_pre_ok) w_next_state = C_PRE_DEST;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_since_act <= 8'd0;
         r_since_pre <= 8'd0;
         open_row    <= '0;
         wr_ack      <= 1'b0;
         err_pulse   <= 1'b0;
         err_code    <= 3'd0;
         err_count   <= 8'd0;
      end else begin
         r_state     <= w_next_state;
         r_since_act <= w_act_ok ? 8'd1 : (r_since_act == 8'hFF ? 8'hFF : r_since_act + 8'd1);
         r_since_pre <= w_pre_ok ? 8'd1 : (r_since_pre == 8'hFF ? 8'hFF : r_since_pre + 8'd1);
         if (w_act_ok) open_row <= cmd_addr[ROW_BITS-1:0];
         wr_ack    <= w_wr_ok;
         err_pulse <= w_err;
         if (w_err) begin
            err_code <= w_err_code;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
         end
      end
   end

   // Read latency pipeline; columns of non-reads are zeroed so rd_col is 0 when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pipe_v <= '0;
         for (int i = 0; i < CL; i++) r_pipe_col[i] <= '0;
      end else begin
         r_pipe_v[0]   <= w_rd_ok;
         r_pipe_col[0] <= w_rd_ok ? cmd_addr[COL_BITS-1:0] : '0;
         for (int i = 1; i < CL; i++) begin
            r_pipe_v[i]   <= r_pipe_v[i-1];
            r_pipe_col[i] <= r_pipe_col[i-1];
         end
      end
   end

   assign bank_open = (r_state == ST_ACTIVATING) || (r_state == ST_ACTIVE);
   assign rd_valid  = r_pipe_v[CL-1];
   assign rd_col    = r_pipe_col[CL-1];

`ifdef DDR3_BANK_MODEL_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         act_count <= 16'd0;
         rd_count  <= 16'd0;
         wr_count  <= 16'd0;
      end else begin
         if (w_act_ok) act_count <= act_count + 16'd1;
         if (w_rd_ok)  rd_count  <= rd_count + 16'd1;
         if (w_wr_ok)  wr_count  <= wr_count + 16'd1;
      end
   end
`else
   assign act_count = 16'd0;
   assign rd_count  = 16'd0;
   assign wr_count  = 16'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ddr3_bank_model.sv
// tb_ddr3_bank_model: directed vector table plus saturation and statistics sequences for ddr3_bank_model.
`default_nettype none

module tb_ddr3_bank_model;
   import ddr3_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        cmd_valid;
   ddr3_cmd_t   cmd_type;
   logic [2:0]  cmd_bank;
   logic [12:0] cmd_addr;
   logic        bank_open;
   logic [12:0] open_row;
   logic        rd_valid;
   logic [9:0]  rd_col;
   logic        wr_ack;
   logic        err_pulse;
   logic [2:0]  err_code;
   logic [7:0]  err_count;
   logic [15:0] act_count, rd_count, wr_count;

   int n_pass = 0;
   int n_total = 0;

   ddr3_bank_model dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_type(cmd_type),
      .cmd_bank(cmd_bank), .cmd_addr(cmd_addr), .bank_open(bank_open),
      .open_row(open_row), .rd_valid(rd_valid), .rd_col(rd_col), .wr_ack(wr_ack),
      .err_pulse(err_pulse), .err_code(err_code), .err_count(err_count),
      .act_count(act_count), .rd_count(rd_count), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        valid;
      ddr3_cmd_t   typ;
      logic [2:0]  bank;
      logic [12:0] addr;
      logic [37:0] exp;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [37:0] e(input logic bo, input logic [12:0] row, input logic rv,
                                     input logic [9:0] col, input logic wa, input logic ep,
                                     input logic [2:0] ec, input logic [7:0] cnt);
      return {bo, row, rv, col, wa, ep, ec, cnt};
   endfunction

   task automatic push(input logic r, input logic v, input ddr3_cmd_t t, input logic [2:0] b,
                       input logic [12:0] a, input logic [37:0] x);
      vec_t tmp;
      tmp.rst = r; tmp.valid = v; tmp.typ = t; tmp.bank = b; tmp.addr = a; tmp.exp = x;
      vecs.push_back(tmp);
   endtask

   task automatic c0(input ddr3_cmd_t t, input logic [12:0] a, input logic [37:0] x);
      push(1'b0, 1'b1, t, 3'd0, a, x);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, req);
   endtask

   function automatic logic [37:0] outs();
      return {bank_open, open_row, rd_valid, rd_col, wr_ack, err_pulse, err_code, err_count};
   endfunction

   task automatic drive(input logic r, input logic v, input ddr3_cmd_t t, input logic [2:0] b,
                        input logic [12:0] a);
      rst = r; cmd_valid = v; cmd_type = t; cmd_bank = b; cmd_addr = a;
      @(posedge clk);
      #1;
   endtask

   logic [37:0] z;
   logic [47:0] stats_exp;

   initial begin
      z = '0;
      // Each vector: command applied in cycle k, outputs checked in cycle k+1.
      push(1'b1, 1'b0, CMD_NOP, 3'd0, 13'h0, z);
      push(1'b1, 1'b0, CMD_NOP, 3'd0, 13'h0, z);
      c0(CMD_ACT, 13'h100, e(1, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));   // c0
      c0(CMD_NOP, 13'h0,   e(1, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(1, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_RD,  13'h050, e(1, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));   // c3
      c0(CMD_RD,  13'h051, e(1, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_WR,  13'h010, e(1, 13'h100, 0, 10'h0, 1, 0, 3'd0, 8'd0));   // c5
      c0(CMD_NOP, 13'h0,   e(1, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(1, 13'h100, 1, 10'h050, 0, 0, 3'd0, 8'd0));
      c0(CMD_PRE, 13'h0,   e(0, 13'h100, 1, 10'h051, 0, 0, 3'd0, 8'd0)); // c8
      c0(CMD_NOP, 13'h0,   e(0, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(0, 13'h100, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_ACT, 13'h200, e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));   // c11
      c0(CMD_NOP, 13'h0,   e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_RD,  13'h070, e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));   // c14
      c0(CMD_NOP, 13'h0,   e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(1, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(1, 13'h200, 1, 10'h070, 0, 0, 3'd0, 8'd0)); // c18
      c0(CMD_PRE, 13'h0,   e(0, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));   // c19
      c0(CMD_NOP, 13'h0,   e(0, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_NOP, 13'h0,   e(0, 13'h200, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_ACT, 13'h300, e(1, 13'h300, 0, 10'h0, 0, 0, 3'd0, 8'd0));   // c22
      c0(CMD_NOP, 13'h0,   e(1, 13'h300, 0, 10'h0, 0, 0, 3'd0, 8'd0));
      c0(CMD_RD,  13'h011, e(1, 13'h300, 0, 10'h0, 0, 1, 3'd2, 8'd1));   // c24 RD < tRCD
      c0(CMD_NOP, 13'h0,   e(1, 13'h300, 0, 10'h0, 0, 0, 3'd2, 8'd1));
      c0(CMD_NOP, 13'h0,   e(1, 13'h300, 0, 10'h0, 0, 0, 3'd2, 8'd1));
      c0(CMD_NOP, 13'h0,   e(1, 13'h300, 0, 10'h0, 0, 0, 3'd2, 8'd1));
      c0(CMD_NOP, 13'h0,   e(1, 13'h300, 0, 10'h0, 0, 0, 3'd2, 8'd1));
      c0(CMD_PRE, 13'h0,   e(1, 13'h300, 0, 10'h0, 0, 1, 3'd3, 8'd2));   // c29 PRE < tRAS
      c0(CMD_PRE, 13'h0,   e(0, 13'h300, 0, 10'h0, 0, 0, 3'd3, 8'd2));   // c30
      c0(CMD_NOP, 13'h0,   e(0, 13'h300, 0, 10'h0, 0, 0, 3'd3, 8'd2));
      c0(CMD_ACT, 13'h400, e(0, 13'h300, 0, 10'h0, 0, 1, 3'd5, 8'd3));   // c32 ACT < tRP
      c0(CMD_ACT, 13'h400, e(1, 13'h400, 0, 10'h0, 0, 0, 3'd5, 8'd3));   // c33
      c0(CMD_ACT, 13'h500, e(1, 13'h400, 0, 10'h0, 0, 1, 3'd4, 8'd4));   // ACT while open
      c0(CMD_WR,  13'h020, e(1, 13'h400, 0, 10'h0, 0, 1, 3'd2, 8'd5));   // WR < tRCD
      c0(ddr3_cmd_t'(3'd5), 13'h0, e(1, 13'h400, 0, 10'h0, 0, 1, 3'd6, 8'd6));
      c0(CMD_NOP, 13'h0,   e(1, 13'h400, 0, 10'h0, 0, 0, 3'd6, 8'd6));
      c0(CMD_RD,  13'h033, e(1, 13'h400, 0, 10'h0, 0, 0, 3'd6, 8'd6));   // c38
      c0(CMD_NOP, 13'h0,   e(1, 13'h400, 0, 10'h0, 0, 0, 3'd6, 8'd6));
      push(1'b1, 1'b0, CMD_NOP, 3'd0, 13'h0, z);                          // c40 reset mid-read
      for (int i = 0; i < 4; i++) c0(CMD_NOP, 13'h0, z);
      push(1'b0, 1'b1, CMD_ACT, 3'd1, 13'h100, z);                        // other bank
      push(1'b0, 1'b1, CMD_NOP, 3'd1, 13'h0, z);
      push(1'b0, 1'b1, CMD_NOP, 3'd1, 13'h0, z);
      push(1'b0, 1'b1, CMD_RD,  3'd1, 13'h055, z);
      for (int i = 0; i < 7; i++) c0(CMD_NOP, 13'h0, z);
      push(1'b0, 1'b1, CMD_PRE, 3'd1, 13'h0, z);
      c0(CMD_PRE, 13'h0, z);                                              // PRE while idle
      push(1'b0, 1'b0, CMD_ACT, 3'd0, 13'h123, z);                        // not valid
      c0(CMD_ACT, 13'h1FFF, e(1, 13'h1FFF, 0, 10'h0, 0, 0, 3'd0, 8'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i].rst, vecs[i].valid, vecs[i].typ, vecs[i].bank, vecs[i].addr);
         check($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      end

`ifdef DDR3_BANK_MODEL_STATS_EN
      stats_exp = {16'd1, 16'd0, 16'd0};
`else
      stats_exp = 48'd0;
`endif
      check("stats", 64'({act_count, rd_count, wr_count}), 64'(stats_exp));

      // Saturation: reads to a closed bank, 260 in a row.
      drive(1'b1, 1'b0, CMD_NOP, 3'd0, 13'h0);
      check("sat_reset", 64'(outs()), 64'(z));
      for (int i = 0; i < 260; i++) begin
         drive(1'b0, 1'b1, CMD_RD, 3'd0, 13'h001);
         check($sformatf("sat%0d", i), 64'({err_pulse, err_code, err_count, rd_valid}),
               64'({1'b1, 3'd1, (i + 1 > 255) ? 8'd255 : 8'(i + 1), 1'b0}));
      end
      drive(1'b0, 1'b1, CMD_NOP, 3'd0, 13'h0);
      check("sat_hold", 64'({err_pulse, err_code, err_count}), 64'({1'b0, 3'd1, 8'd255}));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

`default_nettype wire

// File: doc/ddr3_bank_model.md
Name: ddr3_bank_model

Overview:
- Device-side responder for one DDR3 bank; receives the command stream that the per-bank controller FSM issues through cmd_gen.
- Tracks bank state (row open/closed) and enforces tRCD/tRAS/tRP. Returns read-data-valid CL cycles after a legal READ and acknowledges WRITEs.
- Flags and counts protocol/timing violations.
- Used as the DUT-facing memory stand-in in bank-level and controller-level benches; synthesizable.

Parameters:
BANK_ID, 0, bank this instance responds to
T_RCD, 3, min cycles ACT -> RD/WR
T_RAS, 8, min cycles ACT -> PRE
T_RP, 3, min cycles PRE -> ACT
CL, 5, cycles RD -> rd_valid (>=1)
ROW_BITS, 13, row width (ddr3_pkg value)
COL_BITS, 10, column width (ddr3_pkg value)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command strobe, one command per cycle
cmd_type  in  ddr3_cmd_t  NOP/ACT/RD/WR/PRE (ddr3_pkg encoding)
cmd_bank  in  3  target bank; command ignored unless == BANK_ID
cmd_addr  in  ADDR_WIDTH  row (ACT, low ROW_BITS) or column (RD/WR, low COL_BITS)
bank_open  out  1  row open (ACTIVATING or ACTIVE)
open_row  out  ROW_BITS  currently open row
rd_valid  out  1  read data valid pulse
rd_col  out  COL_BITS  column of the read completing this cycle
wr_ack  out  1  one-cycle pulse, cycle after a legal WR
err_pulse  out  1  one-cycle violation pulse
err_code  out  3  1=RD/WR closed,2=RD/WR<tRCD,3=PRE<tRAS,4=ACT open,5=ACT<tRP,6=unknown cmd; holds last code
err_count  out  8  saturating violation count (stops at 255)
act_count, rd_count, wr_count  out  16 each  stats (see Optional Feature)

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset: all outputs 0; state IDLE; counters cleared; read pipeline flushed. A reset mid-read drops in-flight reads, so no rd_valid follows.
- Command accepted only when cmd_valid=1 and cmd_bank==BANK_ID; otherwise ignored. NOP is always legal and has no effect.
- States: IDLE, ACTIVATING, ACTIVE, PRECHARGING.
- Timestamp counters: since_act and since_pre; 1 in the cycle after the command; saturate at 255.
- ACT at cycle t:
  - legal in IDLE, or in PRECHARGING with since_pre>=T_RP;
  - latches open_row, goes to ACTIVATING, bank_open=1 from t+1.
- ACTIVATING -> ACTIVE when since_act reaches T_RCD.
- RD/WR:
  - legal only in ACTIVE, i.e. at cycle >= t+T_RCD;
  - in ACTIVATING -> code 2; in IDLE/PRECHARGING -> code 1.
- Legal RD at cycle r: rd_valid=1 with rd_col=column at cycle r+CL exactly. Shift-register pipeline, depth CL. Back-to-back RDs every cycle are supported; each produces its own pulse.
- Legal WR at cycle w: wr_ack=1 at w+1.
- PRE:
  - legal in ACTIVE with since_act>=T_RAS -> PRECHARGING, bank_open=0 from next cycle;
  - PRE in IDLE or PRECHARGING: legal no-op;
  - PRE in ACTIVATING or early in ACTIVE -> code 3.
- PRECHARGING -> IDLE when since_pre reaches T_RP.
- ACT in ACTIVATING/ACTIVE -> code 4; ACT in PRECHARGING with since_pre<T_RP -> code 5.
- Unknown cmd_type -> code 6.
- Illegal commands:
  - no state change, no rd_valid/wr_ack;
  - err_pulse=1 the next cycle; err_code updated; err_count incremented unless at 255.
- In-flight reads complete normally even if PRE or an error occurs meanwhile.

Optional Feature:
- Macro DDR3_BANK_MODEL_STATS_EN.
- Defined: act_count/rd_count/wr_count increment on each legal ACT/RD/WR; 16-bit wrap-around; cleared by rst.
- Undefined: counter logic omitted; the three ports are present and tied to 0.

Test Plan:
- Reset, then ACT row 0x100 at cycle 0, RD col 0x060 at cycle 3 -> open_row=0x100, bank_open=1 from cycle 1; rd_valid=1 with rd_col=0x060 at cycle 8; err_count=0.
- Row hit: ACT 0x100, RD 0x050 at +3, RD 0x051 at +4 -> rd_valid at +8 (0x050) and +9 (0x051); WR at +5 -> wr_ack at +6.
- Row miss: ACT 0x100 at 0, PRE at 8, ACT 0x200 at 11, RD 0x070 at 14 -> open_row=0x200; rd_valid/rd_col=0x070 at 19; no errors.
- Timing violations:
  - RD at ACT+2 -> err_code=2;
  - PRE at ACT+7 -> err_code=3;
  - ACT at PRE+2 -> err_code=5;
  - each gives a single err_pulse, state unchanged, err_count=3.
- cmd_bank=1 with BANK_ID=0 (ACT/RD/PRE sequence) -> no state change, no outputs; 260 forced violations -> err_count=255.
- Assert rst two cycles after legal RD -> no rd_valid afterwards, all outputs 0; with DDR3_BANK_MODEL_STATS_EN, rd_count=0 after reset.
